// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: stage indices, stall
// patterns, sequencer state encoding and common constants.
package pipe_ctrl_pkg;

  // Bit positions of each stage inside the stall vector
  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB  = 5;

  localparam int NUM_STAGES = 6;

  // A stalling stage freezes itself and everything upstream of it
  localparam logic [NUM_STAGES-1:0] STALL_NONE = 6'b000000;
  localparam logic [NUM_STAGES-1:0] STALL_IF   = 6'b000011;
  localparam logic [NUM_STAGES-1:0] STALL_ID   = 6'b000111;
  localparam logic [NUM_STAGES-1:0] STALL_EX   = 6'b001111;
  localparam logic [NUM_STAGES-1:0] STALL_MEM  = 6'b011111;

  localparam logic        STOP      = 1'b1;
  localparam logic        NO_STOP   = 1'b0;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_FLUSH    = 2'd2
  } ctrl_state_e;

  // Merge per-stage requests; the most downstream requester decides the pattern
  function automatic logic [NUM_STAGES-1:0] stall_pattern(
    input logic req_if,
    input logic req_id,
    input logic req_ex,
    input logic req_mem
  );
    logic [NUM_STAGES-1:0] pat;
    if (req_mem == STOP) begin
      pat = STALL_MEM;
    end else if (req_ex == STOP) begin
      pat = STALL_EX;
    end else if (req_id == STOP) begin
      pat = STALL_ID;
    end else if (req_if == STOP) begin
      pat = STALL_IF;
    end else begin
      pat = STALL_NONE;
    end
    pat[STG_WB] = NO_STOP;
    return pat;
  endfunction

endpackage

// File: rtl/pipe_ctrl_mem_wdog.sv
// Watchdog on LSU bus waits: counts consecutive mem-stall cycles, saturates,
// and emits one registered pulse when the count first reaches the limit.
module pipe_ctrl_mem_wdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic stallreq_mem_i,
  output logic bus_timeout_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] LIMIT      = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LIMIT_LESS = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_d, cnt_q;
  logic          pulse_d, pulse_q;

  // Next count and pulse: the pulse fires only on the step into the limit
  always_comb begin
    cnt_d   = {CW{1'b0}};
    pulse_d = 1'b0;
    if (stallreq_mem_i) begin
      if (cnt_q == LIMIT) begin
        cnt_d = cnt_q;
      end else begin
        cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
      end
      pulse_d = (cnt_q == LIMIT_LESS);
    end else begin
      cnt_d   = {CW{1'b0}};
      pulse_d = 1'b0;
    end
  end

  // Counter and pulse registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= {CW{1'b0}};
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign bus_timeout_o = pulse_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline sequencer: merges stall requests, sequences trap/mret
// redirects through a RUN/WAIT_MEM/FLUSH machine, and hosts the bus watchdog.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stallreq_if_i,
  input  logic            stallreq_id_i,
  input  logic            stallreq_ex_i,
  input  logic            stallreq_mem_i,
  input  logic            trap_req_i,
  input  logic [XLEN-1:0] trap_vec_i,
  input  logic            mret_req_i,
  input  logic [XLEN-1:0] mret_pc_i,
  output logic [5:0]      stall_o,
  output logic            flush_o,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            trap_ack_o,
  output logic            bus_timeout_o
);

  ctrl_state_e     state_d, state_q;
  logic [XLEN-1:0] target_d, target_q;
  logic            flush_d, flush_q;

  // Stall merge; suppressed while flushing so the flush reaches every stage
  always_comb begin
    if (rst_i || (state_q == ST_FLUSH)) begin
      stall_o = STALL_NONE;
    end else begin
      stall_o = stall_pattern(stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i);
    end
  end

  // Sequencer next state; target is captured only when leaving RUN
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    case (state_q)
      ST_RUN: begin
        if (trap_req_i || mret_req_i) begin
          target_d = trap_req_i ? trap_vec_i : mret_pc_i;
          state_d  = stallreq_mem_i ? ST_WAIT_MEM : ST_FLUSH;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_WAIT_MEM: begin
        if (stallreq_mem_i) begin
          state_d = ST_WAIT_MEM;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
    flush_d = (state_d == ST_FLUSH);
  end

  // Sequencer state and Moore outputs registered together
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_RUN;
      target_q <= XLEN'(ZERO_WORD);
      flush_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      flush_q  <= flush_d;
    end
  end

  assign flush_o       = flush_q;
  assign redirect_o    = flush_q;
  assign trap_ack_o    = flush_q;
  assign redirect_pc_o = target_q;

  pipe_ctrl_mem_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_mem_wdog (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .stallreq_mem_i (stallreq_mem_i),
    .bus_timeout_o  (bus_timeout_o)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: stall table, directed trap/mret/watchdog/
// reset sequences, and randomized traffic against a behavioural model.
module tb_pipe_ctrl;

  localparam int XLEN = 32;
  localparam int TMO  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            s_if, s_id, s_ex, s_mem;
  logic            trap_req, mret_req;
  logic [XLEN-1:0] trap_vec, mret_pc;
  logic [5:0]      stall;
  logic            flush, redirect, ack, tmo;
  logic [XLEN-1:0] rpc;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit              m_waiting;
  bit              m_flushing;
  logic [XLEN-1:0] m_target;
  int              m_streak;
  bit              m_pulse;

  pipe_ctrl #(.XLEN(XLEN), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk), .rst_i(rst),
    .stallreq_if_i(s_if), .stallreq_id_i(s_id), .stallreq_ex_i(s_ex), .stallreq_mem_i(s_mem),
    .trap_req_i(trap_req), .trap_vec_i(trap_vec), .mret_req_i(mret_req), .mret_pc_i(mret_pc),
    .stall_o(stall), .flush_o(flush), .redirect_o(redirect), .redirect_pc_o(rpc),
    .trap_ack_o(ack), .bus_timeout_o(tmo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r_if, r_id, r_ex, r_mem;
    logic [5:0] exp_stall;
  } stall_vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stall vector from the rule: the deepest requesting stage k freezes bits 0..k
  function automatic logic [5:0] exp_stall_of(input logic a, b, c, d);
    int n;
    n = d ? 5 : c ? 4 : b ? 3 : a ? 2 : 0;
    return 6'((1 << n) - 1);
  endfunction

  task automatic check_all();
    logic [5:0] es;
    es = (rst || m_flushing) ? 6'b000000 : exp_stall_of(s_if, s_id, s_ex, s_mem);
    chk("stall_o", 32'(stall), 32'(es));
    chk("flush_o", 32'(flush), 32'(m_flushing));
    chk("redirect_o", 32'(redirect), 32'(m_flushing));
    chk("trap_ack_o", 32'(ack), 32'(m_flushing));
    chk("redirect_pc_o", rpc, m_target);
    chk("bus_timeout_o", 32'(tmo), 32'(m_pulse));
  endtask

  // Advance the model by one clock edge using the inputs currently applied
  task automatic model_step();
    bit nf;
    if (rst) begin
      m_waiting = 1'b0; m_flushing = 1'b0; m_target = '0; m_streak = 0; m_pulse = 1'b0;
    end else begin
      nf = 1'b0;
      if (m_flushing) begin
        m_waiting = 1'b0;
      end else if (m_waiting) begin
        if (!s_mem) begin nf = 1'b1; m_waiting = 1'b0; end
      end else if (trap_req || mret_req) begin
        m_target = trap_req ? trap_vec : mret_pc;
        if (s_mem) m_waiting = 1'b1; else nf = 1'b1;
      end
      m_flushing = nf;
      if (s_mem) m_streak++; else m_streak = 0;
      m_pulse = (m_streak == TMO);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    s_if = 1'b0; s_id = 1'b0; s_ex = 1'b0; s_mem = 1'b0;
    trap_req = 1'b0; mret_req = 1'b0;
  endtask

  initial begin
    stall_vec_t tbl[7];
    int pulses, pulse_idx;

    m_waiting = 1'b0; m_flushing = 1'b0; m_target = '0; m_streak = 0; m_pulse = 1'b0;
    rst = 1'b1; idle_inputs(); trap_vec = '0; mret_pc = '0;
    cycle(); cycle();
    chk("reset flush", 32'(flush), 32'd0);
    chk("reset pc", rpc, 32'h0);
    chk("reset stall", 32'(stall), 32'd0);
    rst = 1'b0;
    cycle();

    // Stall priority table
    tbl[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 6'b001111};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 6'b011111};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'b000011};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 6'b000111};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 6'b011111};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 6'b001111};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'b000000};
    for (int i = 0; i < 7; i++) begin
      s_if = tbl[i].r_if; s_id = tbl[i].r_id; s_ex = tbl[i].r_ex; s_mem = tbl[i].r_mem;
      #2;
      chk($sformatf("stall_tbl[%0d]", i), 32'(stall), 32'(tbl[i].exp_stall));
      cycle();
    end
    idle_inputs(); cycle();

    // Plain trap: request at N, flush at N+1, back to RUN at N+2
    trap_req = 1'b1; trap_vec = 32'h8000_0100;
    cycle();
    chk("trap flush N+1", 32'(flush), 32'd1);
    chk("trap ack N+1", 32'(ack), 32'd1);
    chk("trap pc N+1", rpc, 32'h8000_0100);
    chk("trap stall N+1", 32'(stall), 32'd0);
    cycle();
    trap_req = 1'b0;
    chk("trap flush N+2", 32'(flush), 32'd0);
    cycle();

    // Trap behind a mem wait; the later vector change must not be taken
    s_mem = 1'b1; cycle();
    trap_req = 1'b1; trap_vec = 32'h0000_0100; cycle();
    trap_vec = 32'h0000_0200;
    for (int i = 0; i < 3; i++) begin
      chk("wait no flush", 32'(flush), 32'd0);
      chk("wait stall", 32'(stall), 32'h1f);
      cycle();
    end
    s_mem = 1'b0; cycle();
    chk("wait flush", 32'(flush), 32'd1);
    chk("wait pc", rpc, 32'h0000_0100);
    cycle();
    trap_req = 1'b0; cycle();

    // Simultaneous trap and mret: trap wins; then mret alone
    trap_req = 1'b1; mret_req = 1'b1; trap_vec = 32'h100; mret_pc = 32'h2000_0040;
    cycle();
    chk("trap wins pc", rpc, 32'h100);
    cycle();
    trap_req = 1'b0; mret_req = 1'b0; cycle();
    mret_req = 1'b1; cycle();
    chk("mret flush", 32'(flush), 32'd1);
    chk("mret pc", rpc, 32'h2000_0040);
    cycle();
    mret_req = 1'b0; cycle();

    // Watchdog: one pulse over a 10-cycle wait, none over a 3-cycle wait
    pulses = 0; pulse_idx = -1;
    s_mem = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (tmo) begin pulses++; pulse_idx = i; end
    end
    chk("wdog pulses", 32'(pulses), 32'd1);
    chk("wdog pulse cycle", 32'(pulse_idx), 32'd3);
    s_mem = 1'b0; cycle();
    pulses = 0;
    s_mem = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (tmo) pulses++;
    end
    chk("wdog short", 32'(pulses), 32'd0);
    s_mem = 1'b0; cycle();

    // Reset in the middle of a mem wait
    s_mem = 1'b1; trap_req = 1'b1; trap_vec = 32'h300; cycle();
    rst = 1'b1; trap_req = 1'b0;
    #1;
    chk("rst stall", 32'(stall), 32'd0);
    cycle();
    chk("rst flush", 32'(flush), 32'd0);
    chk("rst pc", rpc, 32'h0);
    rst = 1'b0; s_mem = 1'b0;
    cycle();
    chk("post-rst flush a", 32'(flush), 32'd0);
    cycle();
    chk("post-rst flush b", 32'(flush), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      rst      = ($urandom_range(0, 99) < 2);
      s_if     = ($urandom_range(0, 3) == 0);
      s_id     = ($urandom_range(0, 3) == 0);
      s_ex     = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 9) < 2) s_mem = ~s_mem;
      trap_req = ($urandom_range(0, 9) < 2);
      mret_req = ($urandom_range(0, 9) < 2);
      trap_vec = $urandom;
      mret_pc  = $urandom;
      cycle();
    end
    rst = 1'b0; idle_inputs(); cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline sequencer for the 6-stage core (pc, if, id, ex, mem, wb). It merges per-stage stall requests into the 6-bit stall vector consumed by every pipeline register. It sequences trap and mret redirects through a small FSM that drives the global flush and the PC redirect. It also runs a watchdog on outstanding LSU bus waits.

Parameters:
XLEN, 32, width of PC/vector values
TIMEOUT_CYCLES, 255, consecutive mem-stall cycles before bus_timeout_o pulses (must be >= 2)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
stallreq_if_i  in  1  fetch bus wait
stallreq_id_i  in  1  load-use hazard
stallreq_ex_i  in  1  multi-cycle EX op busy (div)
stallreq_mem_i  in  1  LSU bus wait
trap_req_i  in  1  trap request, level, held until trap_ack_o
trap_vec_i  in  XLEN  trap handler address (mtvec-derived)
mret_req_i  in  1  mret request, level, held until trap_ack_o
mret_pc_i  in  XLEN  mepc value
stall_o  out  6  stall vector; bit k=1 stops stage k (0=pc … 5=wb)
flush_o  out  1  flush all pipeline registers
redirect_o  out  1  load redirect_pc_o into PC
redirect_pc_o  out  XLEN  redirect target
trap_ack_o  out  1  request accepted (one-cycle pulse)
bus_timeout_o  out  1  watchdog expiry pulse

Behaviour:
- Stall vector is combinational from requests, highest stage wins:
  - mem: 011111
  - else ex: 001111
  - else id: 000111
  - else if: 000011
  - else 000000
- stall_o is forced to 000000 in FLUSH state and while rst_i=1.
- FSM states:
  - RUN:
    - trap_req_i or mret_req_i with stallreq_mem_i=0 -> FLUSH.
    - Same request with stallreq_mem_i=1 -> WAIT_MEM.
    - Target is latched on the transition: trap_vec_i if trap_req_i, else mret_pc_i.
  - WAIT_MEM:
    - stall_o still follows requests.
    - Stays while stallreq_mem_i=1; -> FLUSH on the first cycle it is 0.
    - Target is NOT relatched.
  - FLUSH:
    - Exactly one cycle: flush_o=1, redirect_o=1, trap_ack_o=1, redirect_pc_o=latched target.
    - Always -> RUN.
- flush_o, redirect_o and trap_ack_o are Moore outputs from state; they are 0 in RUN and WAIT_MEM.
- redirect_pc_o holds its last latched value and is 0 after reset.
- Latency: a request sampled in RUN at cycle N with no mem stall gives flush_o at N+1.
- Simultaneous trap_req_i and mret_req_i: trap wins.
- Requests seen in FLUSH are ignored. Requesters must drop their request the cycle after trap_ack_o; a request still high in the next RUN cycle is a new request.
- Watchdog:
  - Counter cnt, width $clog2(TIMEOUT_CYCLES)+1.
  - Cleared when stallreq_mem_i=0; otherwise increments and saturates at TIMEOUT_CYCLES.
  - bus_timeout_o is a registered one-cycle pulse on the cycle cnt transitions to TIMEOUT_CYCLES.
  - No further pulse until stallreq_mem_i drops.
  - The block does not break the stall itself.
- Reset (any state, including mid-WAIT_MEM): state=RUN, cnt=0, latched target=0, all registered outputs 0.

Decomposition:
- Shared defines package:
  - Stall-vector stage indices and the four stall patterns.
  - FSM state encodings (RUN=2'd0, WAIT_MEM=2'd1, FLUSH=2'd2).
  - Existing `Stop/`NO_STOP, `ZERO_WORD.
- One natural sub-module: mem_wdog (saturating counter plus pulse), instantiated once.

Test Plan:
- Stall priority:
  - stallreq_id_i=1, stallreq_ex_i=1 -> stall_o=001111.
  - Add stallreq_mem_i=1 -> 011111.
  - Only stallreq_if_i -> 000011.
- Plain trap: RUN, trap_req_i=1, trap_vec_i=0x8000_0100, no mem stall at cycle N.
  - Cycle N+1: flush_o=redirect_o=trap_ack_o=1, redirect_pc_o=0x8000_0100, stall_o=0.
  - Cycle N+2: back to RUN, outputs 0.
- Trap behind mem wait: stallreq_mem_i=1 for 5 cycles, trap_req_i rises at cycle 1 with vec 0x100, then vec changes to 0x200.
  - No flush while stall is high; stall_o=011111.
  - flush_o on the cycle after stallreq_mem_i falls, with redirect_pc_o=0x100.
- Trap vs mret simultaneous: trap_vec=0x100, mret_pc=0x2000_0040 -> redirect_pc_o=0x100.
  - mret alone -> redirect_pc_o=0x2000_0040.
- Watchdog, TIMEOUT_CYCLES=4:
  - stallreq_mem_i held 10 cycles -> exactly one bus_timeout_o pulse, on the cycle cnt reaches 4.
  - Drop then reassert for 3 cycles -> no pulse.
- Reset mid-operation: rst_i=1 during WAIT_MEM -> next cycle state RUN, flush_o=0, stall_o=0 during reset, redirect_pc_o=0, and no flush after release.
